sync_fifo_param: RTL and testbench

//  Single-clock, parametrised FIFO with occupancy count and programmable almost-full/almost-empty flags.

---
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with count, programmable flags and optional FWFT
// Works for any DEPTH >= 2; pointers wrap by explicit compare rather than by power-of-two overflow.
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 409,
   parameter int AFULL_TH   = 400,
   parameter int AEMPTY_TH  = 8,
   parameter int FWFT       = 0,
   localparam int ADDR_W    = $clog2(DEPTH),
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  AFULL_C   = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0]  AEMPTY_C  = CNT_W'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     waddr;
   logic [ADDR_W-1:0]     raddr;
   logic                  wr_ok;
   logic                  rd_ok;
   logic [CNT_W-1:0]      count_next;

   // Accept decisions use the registered full/empty from before the edge.
   always_comb begin
      wr_ok      = w_en & ~full & ~flush;
      rd_ok      = r_en & ~empty & ~flush;
      count_next = count;
      if (flush)
         count_next = '0;
      else if (wr_ok && !rd_ok)
         count_next = count + CNT_W'(1);
      else if (rd_ok && !wr_ok)
         count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr        <= '0;
         raddr        <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (flush) begin
            waddr     <= '0;
            raddr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_ok)
               waddr <= (waddr == LAST_ADDR) ? '0 : waddr + ADDR_W'(1);
            if (rd_ok)
               raddr <= (raddr == LAST_ADDR) ? '0 : raddr + ADDR_W'(1);
            if (w_en && full)
               overflow <= 1'b1;
            if (r_en && empty)
               underflow <= 1'b1;
         end
         // Flags come from next-count so they always agree with count.
         count        <= count_next;
         full         <= (count_next == DEPTH_C);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AFULL_C);
         almost_empty <= (count_next <= AEMPTY_C);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[waddr] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem[raddr];
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               data_out <= '0;
            else if (flush)
               data_out <= '0;
            else if (rd_ok)
               data_out <= mem[raddr];
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param in registered and FWFT modes
module tb_sync_fifo_param;

   localparam int DW     = 8;
   localparam int DEPTH  = 409;
   localparam int AFULL  = 400;
   localparam int AEMPTY = 8;
   localparam int CW     = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, afull0, aempty0, ovf0, unf0;
   logic          full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [CW-1:0] count0, count1;

   int errors = 0;
   int checks = 0;

   // Reference model: a plain queue plus sticky flags and the registered read word.
   logic [DW-1:0] q[$];
   logic          m_ovf, m_unf;
   logic [DW-1:0] m_dout;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
      .count(count0), .overflow(ovf0), .underflow(unf0));

   sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY), .FWFT(1)) dut_fw (
      .clk(clk), .rst_n(rst_n), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
      .count(count1), .overflow(ovf1), .underflow(unf1));

   typedef struct {
      logic          we;
      logic [DW-1:0] d;
      logic          re;
      logic          fl;
      int            cnt;
      logic          emp;
      logic          aemp;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = '0;
   endtask

   task automatic model_edge();
      bit was_full, was_empty, wr, rd;
      if (flush) begin
         model_reset();
         return;
      end
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wr = w_en && !was_full;
      rd = r_en && !was_empty;
      if (w_en && was_full)  m_ovf = 1'b1;
      if (r_en && was_empty) m_unf = 1'b1;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(data_in);
   endtask

   task automatic compare_all();
      int sz;
      sz = q.size();
      check("count", 32'(count0), sz);
      check("full", 32'(full0), 32'(sz == DEPTH));
      check("empty", 32'(empty0), 32'(sz == 0));
      check("almost_full", 32'(afull0), 32'(sz >= AFULL));
      check("almost_empty", 32'(aempty0), 32'(sz <= AEMPTY));
      check("overflow", 32'(ovf0), 32'(m_ovf));
      check("underflow", 32'(unf0), 32'(m_unf));
      check("data_out", 32'(dout0), 32'(m_dout));
      check("fw_count", 32'(count1), sz);
      check("fw_flags", {28'b0, full1, empty1, ovf1, unf1},
            {28'b0, sz == DEPTH, sz == 0, m_ovf, m_unf});
      check("fw_aflags", {30'b0, afull1, aempty1}, {30'b0, sz >= AFULL, sz <= AEMPTY});
      if (sz != 0)
         check("fw_data_out", 32'(dout1), 32'(q[0]));
   endtask

   task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input logic fl);
      w_en = we; data_in = d; r_en = re; flush = fl;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      w_en = 1'b0; r_en = 1'b0; flush = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // Basic write/read sequence, then flush with a competing write.
      tbl[0]  = '{1, 8'h01, 0, 0, 1, 0, 1, 8'h00};
      tbl[1]  = '{1, 8'h02, 0, 0, 2, 0, 1, 8'h00};
      tbl[2]  = '{1, 8'h03, 0, 0, 3, 0, 1, 8'h00};
      tbl[3]  = '{1, 8'h04, 0, 0, 4, 0, 1, 8'h00};
      tbl[4]  = '{1, 8'h05, 0, 0, 5, 0, 1, 8'h00};
      tbl[5]  = '{0, 8'h00, 1, 0, 4, 0, 1, 8'h01};
      tbl[6]  = '{0, 8'h00, 1, 0, 3, 0, 1, 8'h02};
      tbl[7]  = '{0, 8'h00, 1, 0, 2, 0, 1, 8'h03};
      tbl[8]  = '{0, 8'h00, 1, 0, 1, 0, 1, 8'h04};
      tbl[9]  = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h05};
      tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 1, 8'h05};
      tbl[11] = '{1, 8'h77, 0, 0, 1, 0, 1, 8'h05};
      tbl[12] = '{1, 8'h88, 0, 1, 0, 1, 1, 8'h00};
      tbl[13] = '{0, 8'h00, 0, 0, 0, 1, 1, 8'h00};
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].we, tbl[i].d, tbl[i].re, tbl[i].fl);
         check($sformatf("tbl%0d_count", i), 32'(count0), tbl[i].cnt);
         check($sformatf("tbl%0d_empty", i), 32'(empty0), 32'(tbl[i].emp));
         check($sformatf("tbl%0d_aempty", i), 32'(aempty0), 32'(tbl[i].aemp));
         check($sformatf("tbl%0d_dout", i), 32'(dout0), 32'(tbl[i].dout));
      end

      // Fill to full, overflow attempt, read everything back.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i * 7 + 3), 1'b0, 1'b0);
      check("fill_full", 32'(full0), 1);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      check("ovf_set", 32'(ovf0), 1);
      check("ovf_count", 32'(count0), DEPTH);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle();
      step(1'b0, '0, 1'b0, 1'b1);

      // Pointer wrap past the last index.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++)   step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++)   step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_count", 32'(count0), 0);

      // Simultaneous read and write while full, then while empty.
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      check("rw_full_count", 32'(count0), DEPTH - 1);
      check("rw_full_ovf", 32'(ovf0), 1);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      check("rw_empty_count", 32'(count0), 1);
      check("rw_empty_unf", 32'(unf0), 1);
      step(1'b0, '0, 1'b0, 1'b1);

      // First-word-fall-through presentation.
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      check("fwft_not_empty", 32'(empty1), 0);
      check("fwft_head", 32'(dout1), 32'hA5);
      idle();
      check("fwft_hold", 32'(dout1), 32'hA5);
      step(1'b0, '0, 1'b1, 1'b0);
      check("fwft_pop_empty", 32'(empty1), 1);

      // Asynchronous reset mid-burst, then flush with a write pending.
      for (int i = 0; i < 37; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      async_reset();
      check("rst_count", 32'(count0), 0);
      check("rst_empty", 32'(empty0), 1);
      step(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b1);
      check("flush_count", 32'(count0), 0);
      check("flush_errs", {30'b0, ovf0, unf0}, 0);
      idle();

      // Randomised traffic in write-heavy, read-heavy and balanced phases.
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 700; i++) begin
            int wp;
            wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
            step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 499) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
